apb_req_arbiter: RTL and testbench

- Shares the single APB master port (psel/penable/pwrite/paddr/pwdata) between NUM_REQ independent requesters, e.g. the AHB-to-APB bridge path plus a config/debug master.
- Arbitrates round-robin and sequences each granted request through the APB SETUP and ACCESS phases, honouring pready and pslverr.
- Returns read data and a completion pulse to the winning requester.
- Sits between the requester front-ends and the APB slaves; psel is the 3-bit one-hot slave select used throughout the bridge.

---
 rtl/apb_req_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that shares one APB master port
// between NUM_REQ requesters. It runs each granted request through the
// SETUP and ACCESS phases and returns a done pulse, read data and the
// error status to the winner. All outputs are registered.
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, an ACCESS
// phase that waits TIMEOUT_CYC cycles for pready is aborted with slverr=1.
module apb_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*3-1:0]   req_sel,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            rdata,
  output logic                   slverr,
  output logic                   busy,
  output logic [2:0]             psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [31:0]            paddr,
  output logic [31:0]            pwdata,
  input  logic [31:0]            prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [2:0]           psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 slverr_q, slverr_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

  // A requester whose done is pulsing is masked so it cannot win twice in a row.
  logic [NUM_REQ-1:0]   eligible;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  int                   cand;

  assign eligible = req & ~done_q;

  // Round-robin search: first eligible index above last, wrapping around.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!grant_found && eligible[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    busy_d    = busy_q;
    done_d    = '0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 3'b000;
        penable_d = 1'b0;
        if (grant_found) begin
          grant_d  = grant_idx;
          psel_d   = req_sel[3*grant_idx +: 3];
          pwrite_d = req_write[grant_idx];
          paddr_d  = req_addr[32*grant_idx +: 32];
          pwdata_d = req_wdata[32*grant_idx +: 32];
          busy_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          psel_d          = 3'b000;
          penable_d       = 1'b0;
          busy_d          = 1'b0;
          done_d[grant_q] = 1'b1;
          slverr_d        = pslverr;
          if (!pwrite_q) begin
            rdata_d = prdata;
          end
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // The slave never answered: close the transfer with an error.
          psel_d          = 3'b000;
          penable_d       = 1'b0;
          busy_d          = 1'b0;
          done_d[grant_q] = 1'b1;
          slverr_d        = 1'b1;
          rdata_d         = '0;
          last_d          = grant_q;
          state_d         = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      psel_q    <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign done    = done_q;
  assign rdata   = rdata_q;
  assign slverr  = slverr_q;
  assign busy    = busy_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter (NUM_REQ=2). Stimulus pushes the
// expected bus phase and completion of each transfer into a queue; a
// monitor compares the bus while busy and pops an entry on every done.
module tb_apb_req_arbiter;

  localparam int NR = 2;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR*32-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*3-1:0]   req_sel;
  logic [NR-1:0]     done;
  logic [31:0]       rdata;
  logic              slverr;
  logic              busy;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  always #5 hclk = ~hclk;

  apb_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .done      (done),
    .rdata     (rdata),
    .slverr    (slverr),
    .busy      (busy),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic [NR-1:0] done;
    logic          slverr;
    logic [31:0]   rdata;
    logic [2:0]    sel;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks      = 0;
  int          failures    = 0;
  int          wait_states = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: insert wait_states low-pready cycles into each ACCESS phase.
  initial begin
    pready = 1'b1;
    forever begin
      @(negedge hclk);
      if (penable && wait_states > 0) begin
        pready = 1'b0;
        wait_states--;
      end else begin
        pready = 1'b1;
      end
    end
  end

  // Monitor: bus fields while busy, completion fields on each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (!hreset) begin
        if (busy) begin
          check("sb_pending_bus", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("bus_psel",   32'(psel),   32'(exp_q[0].sel));
            check("bus_pwrite", 32'(pwrite), 32'(exp_q[0].wr));
            check("bus_paddr",  paddr,       exp_q[0].addr);
            check("bus_pwdata", pwdata,      exp_q[0].wdata);
          end
        end
        if (done != '0) begin
          check("sb_pending_done", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_vec", 32'(done),   32'(e.done));
            check("slverr",   32'(slverr), 32'(e.slverr));
            check("rdata",    rdata,       e.rdata);
          end
        end
      end
    end
  end

  function automatic exp_t mk_exp(input int i, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] sel,
                                  input logic err);
    exp_t e;
    e.done    = '0;
    e.done[i] = 1'b1;
    e.slverr  = err;
    e.rdata   = model_rdata;
    e.sel     = sel;
    e.wr      = wr;
    e.addr    = addr;
    e.wdata   = wdata;
    return e;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] sel);
    req_write[i]        = wr;
    req_addr[32*i +: 32]  = addr;
    req_wdata[32*i +: 32] = wdata;
    req_sel[3*i +: 3]     = sel;
  endtask

  // One transfer from requester i; called at posedge+1 with the arbiter idle.
  task automatic do_xfer(input int i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] sel,
                         input logic [31:0] rd, input logic err, input int waits,
                         input bit drop_early, input bit tmo, output int cyc);
    prdata      = rd;
    pslverr     = err;
    wait_states = waits;
    if (tmo) model_rdata = 32'h0;
    else if (!wr) model_rdata = rd;
    exp_q.push_back(mk_exp(i, wr, addr, wdata, sel, tmo ? 1'b1 : err));
    set_req(i, wr, addr, wdata, sel);
    req[i] = 1'b1;
    cyc = 0;
    while (cyc < 200 && !done[i]) begin
      @(posedge hclk); #1;
      cyc++;
      if (cyc == 1) begin
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_busy",    32'(busy),    32'd1);
        if (drop_early) begin
          req[i] = 1'b0;
          set_req(i, ~wr, 32'hBAD0_0000, 32'hBAD1_1111, ~sel);
        end
      end
      if (cyc == 2) check("access_penable", 32'(penable), 32'd1);
    end
    check("xfer_done_seen", 32'(done[i]), 32'd1);
    req[i] = 1'b0;
    @(posedge hclk); #1;
  endtask

  initial begin
    int c, n, t, last_t;
    exp_t e;

    hreset    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_sel   = '0;
    prdata    = 32'h0;
    pslverr   = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_psel",    32'(psel),    32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_paddr",   paddr,        32'd0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Zero-wait write from requester 0.
    do_xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b001, 32'h0, 1'b0, 0, 1'b0, 1'b0, c);
    check("t1_latency", 32'(c), 32'd3);

    // Read from requester 1 with three wait states.
    do_xfer(1, 1'b0, 32'h0000_0020, 32'h0, 3'b010, 32'h1234_5678, 1'b0, 3, 1'b0, 1'b0, c);
    check("t2_latency", 32'(c), 32'd6);

    // Both requesting continuously: grants 0,1,0,1 every three cycles.
    prdata      = 32'h0;
    pslverr     = 1'b0;
    wait_states = 0;
    set_req(0, 1'b1, 32'h0000_0100, 32'hA0A0_A0A0, 3'b001);
    set_req(1, 1'b1, 32'h0000_0200, 32'hB1B1_B1B1, 3'b100);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk_exp(k % 2, 1'b1, (k % 2 == 0) ? 32'h100 : 32'h200,
                             (k % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1,
                             (k % 2 == 0) ? 3'b001 : 3'b100, 1'b0));
    end
    req    = 2'b11;
    n      = 0;
    t      = 0;
    last_t = 0;
    while (n < 4 && t < 100) begin
      @(posedge hclk); #1;
      t++;
      if (done != '0) begin
        n++;
        if (n > 1) check("t3_gap", 32'(t - last_t), 32'd3);
        last_t = t;
      end
    end
    req = '0;
    check("t3_count", 32'(n), 32'd4);
    @(posedge hclk); #1;

    // req_sel of zero, requester drops req and changes inputs after grant.
    do_xfer(1, 1'b0, 32'h0000_0044, 32'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 1, 1'b1, 1'b0, c);
    check("t6_latency", 32'(c), 32'd4);

    // Slave error on a write: slverr set, rdata untouched.
    do_xfer(0, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 3'b100, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0, c);
    check("t5_latency", 32'(c), 32'd3);

    // Reset in the middle of an ACCESS phase from requester 1.
    prdata      = 32'h7777_7777;
    pslverr     = 1'b0;
    wait_states = 100;
    exp_q.push_back(mk_exp(1, 1'b1, 32'h0000_0050, 32'h9999_9999, 3'b010, 1'b0));
    set_req(1, 1'b1, 32'h0000_0050, 32'h9999_9999, 3'b010);
    req[1] = 1'b1;
    n = 0;
    while (n < 10 && !penable) begin
      @(posedge hclk); #1;
      n++;
    end
    check("t4_in_access", 32'(penable), 32'd1);
    #1 hreset = 1'b1;
    #1;
    check("t4_psel",    32'(psel),    32'd0);
    check("t4_penable", 32'(penable), 32'd0);
    check("t4_pwrite",  32'(pwrite),  32'd0);
    check("t4_paddr",   paddr,        32'd0);
    check("t4_pwdata",  pwdata,       32'd0);
    check("t4_rdata",   rdata,        32'd0);
    check("t4_slverr",  32'(slverr),  32'd0);
    check("t4_busy",    32'(busy),    32'd0);
    check("t4_done",    32'(done),    32'd0);
    exp_q.delete();
    model_rdata = 32'h0;
    req         = '0;
    wait_states = 0;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    @(posedge hclk); #1;

    // After reset requester 0 must win against requester 1.
    prdata = 32'h0BAD_CAFE;
    set_req(0, 1'b0, 32'h0000_0060, 32'h0, 3'b001);
    set_req(1, 1'b1, 32'h0000_0070, 32'h1357_9BDF, 3'b010);
    model_rdata = 32'h0BAD_CAFE;
    exp_q.push_back(mk_exp(0, 1'b0, 32'h60, 32'h0, 3'b001, 1'b0));
    exp_q.push_back(mk_exp(1, 1'b1, 32'h70, 32'h1357_9BDF, 3'b010, 1'b0));
    req = 2'b11;
    n   = 0;
    t   = 0;
    while (n < 2 && t < 50) begin
      @(posedge hclk); #1;
      t++;
      if (done != '0) begin
        if (n == 0) check("t4_first_grant", 32'(done), 32'd1);
        n++;
        if (done[0]) req[0] = 1'b0;
      end
    end
    req = '0;
    check("t4_count", 32'(n), 32'd2);
    @(posedge hclk); #1;

`ifdef ARB_TIMEOUT_EN
    // Slave never ready: abort after 16 ACCESS cycles.
    do_xfer(0, 1'b0, 32'h0000_0080, 32'h0, 3'b001, 32'hDDDD_DDDD, 1'b0, 1000, 1'b0, 1'b1, c);
    check("tmo_latency", 32'(c), 32'd18);
    wait_states = 0;
`endif

    repeat (3) @(posedge hclk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
